// File: rtl/pipeline_memstage.sv
// MEM-stage access controller: drives the data-cache request from the EX/MEM latch, stalls
// until dhit, holds a finished access while the pipeline is frozen, and implements LL/SC.
module pipeline_memstage #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              pipe_en,
   input  logic              dmemREN_l,
   input  logic              dmemWEN_l,
   input  logic              ll_l,
   input  logic              sc_l,
   input  logic [ADDR_W-1:0] porto_l,
   input  logic [DATA_W-1:0] rdat2_l,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   input  logic              ccinv,
   input  logic [ADDR_W-1:0] ccsnoopaddr,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [ADDR_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic [DATA_W-1:0] memdata,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e              state_q, state_d;
   logic                link_valid_q, link_valid_d;
   logic [ADDR_W-1:0]   link_addr_q, link_addr_d;
   logic [DATA_W-1:0]   held_q, held_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic                link_match;
   logic                sc_fail;
   logic                req;
   logic                idle_act;
   logic                acc_done;
   logic [DATA_W-1:0]   access_data;

   assign link_match  = link_valid_q & (link_addr_q == porto_l);
   assign sc_fail     = sc_l & ~link_match;
   assign req         = (dmemREN_l | dmemWEN_l) & ~sc_fail;
   // Only an unflushed IDLE cycle can issue or complete an access
   assign idle_act    = (state_q == StIdle) & ~flush;
   assign acc_done    = idle_act & req & dhit;
   assign access_data = sc_l ? {{(DATA_W-1){1'b0}}, ~sc_fail} : dmemload;

   assign dmemaddr    = porto_l;
   assign dmemstore   = rdat2_l;
   assign stall_cnt   = stall_cnt_q;

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: park in HOLD when the access completes but the latch is frozen
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:  if (req && dhit && !pipe_en) state_d = StHold;
            StHold:  if (pipe_en) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Outputs: requests only from unflushed IDLE, all control forced low during reset
   always_comb begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      mem_stall = 1'b0;
      memdata   = access_data;
      if (!flush) begin
         case (state_q)
            StIdle: begin
               dmemREN   = req & dmemREN_l;
               dmemWEN   = req & dmemWEN_l;
               mem_stall = req & ~dhit;
            end
            StHold:  memdata = held_q;
            default: memdata = access_data;
         endcase
      end
      if (!nRST) begin
         dmemREN   = 1'b0;
         dmemWEN   = 1'b0;
         mem_stall = 1'b0;
      end
   end

   // Held result and link register next-state
   always_comb begin
      held_d       = held_q;
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      if (acc_done && !pipe_en) held_d = access_data;
      if (acc_done && ll_l) begin
         link_valid_d = 1'b1;
         link_addr_d  = porto_l;
      end
      if (acc_done && sc_l) link_valid_d = 1'b0;
      if (acc_done && dmemWEN_l && !sc_l && (porto_l == link_addr_q)) link_valid_d = 1'b0;
      if (idle_act && sc_fail && pipe_en) link_valid_d = 1'b0;
      // Compare against the updated address so a snoop racing an LL to it wins
      if (ccinv && (ccsnoopaddr == link_addr_d)) link_valid_d = 1'b0;
   end

   // Saturating stall counter next-state
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (mem_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Data registers: held result, link, stall counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         held_q       <= '0;
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
         stall_cnt_q  <= '0;
      end else begin
         held_q       <= held_d;
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule
